// File: rtl/surfturf_cmdqueue.sv
// surfturf_cmdqueue: Wishbone-fed multi-channel AXI4-Stream command FIFOs.
// Optional per-channel drop counters: define SURFTURF_CMDQUEUE_DROPCNT_EN.
module surfturf_cmdqueue #(
  parameter int NCH        = 4,
  parameter int DATA_BITS  = 15,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [9:0]               wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic [31:0]              wb_dat_o,
  output logic [NCH*DATA_BITS-1:0] cmd_tdata,
  output logic [NCH-1:0]           cmd_tvalid,
  input  logic [NCH-1:0]           cmd_tready,
  output logic                     overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] P_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic ack;
  logic req;
  logic wr;
  logic [7:0] adr;
  logic [3:0] idx;
  logic data_hit;
  logic ctrl_wr;
  logic ovf_wr;
  logic [NCH-1:0] en;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] ovf_clr;
  logic [NCH-1:0] drop_v;
  logic [NCH-1:0] empty_v;
  logic [NCH-1:0] full_v;
  logic [CW-1:0] cnt_v [NCH];
  logic [15:0] dcnt_v [NCH];
  logic unused_ok;

  assign unused_ok = ^{wb_dat_i, wb_adr_i[9:8], wb_sel_i[3:2]};

  assign req = wb_cyc_i & wb_stb_i;
  assign wb_ack_o = ack & wb_cyc_i;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign wr = req & wb_we_i & wb_ack_o;
  assign adr = wb_adr_i[7:0];
  assign idx = adr[5:2];
  assign data_hit = (adr[7:6] == 2'b01) && (adr[1:0] == 2'b00);
  assign ctrl_wr = wr & (adr == 8'h00);
  assign ovf_wr = wr & (adr == 8'h08) & wb_sel_i[0];
  assign ovf_clr = ovf_wr ? wb_dat_i[NCH-1:0] : '0;
  assign overflow_o = |ovf;

  // Single-cycle ack pulse per request
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) ack <= 1'b0;
    else ack <= req & ~ack;
  end

  // Channel enables
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) en <= '1;
    else if (ctrl_wr & wb_sel_i[1]) en <= wb_dat_i[8 +: NCH];
  end

  // Sticky overflow; a new drop beats a same-cycle clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) ovf <= '0;
    else ovf <= (ovf & ~ovf_clr) | drop_v;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2-1:0] wp;
    logic [CW-1:0] cnt;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic flush;
    logic push_req;
    logic pop;
    logic push_ok;

    assign flush = ctrl_wr & wb_sel_i[0] & wb_dat_i[c];
    assign push_req = wr & data_hit & (idx == 4'(c)) & wb_sel_i[0];
    assign empty_v[c] = (cnt == '0);
    assign full_v[c] = (cnt == C_FULL);
    assign cmd_tvalid[c] = en[c] & ~empty_v[c];
    assign pop = cmd_tvalid[c] & cmd_tready[c] & ~flush;
    assign push_ok = push_req & ~flush & (~full_v[c] | pop);
    assign drop_v[c] = push_req & ~flush & full_v[c] & ~pop;
    assign cnt_v[c] = cnt;
    assign cmd_tdata[c*DATA_BITS +: DATA_BITS] =
      empty_v[c] ? '0 : mem[rp];

    // Pointer and occupancy tracking
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else if (flush) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        if (push_ok) wp <= wp + P_ONE;
        if (pop) rp <= rp + P_ONE;
        unique case ({push_ok, pop})
          2'b10: cnt <= cnt + C_ONE;
          2'b01: cnt <= cnt - C_ONE;
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage array, not reset
    always_ff @(posedge wb_clk_i) begin
      if (push_ok) mem[wp] <= wb_dat_i[DATA_BITS-1:0];
    end

`ifdef SURFTURF_CMDQUEUE_DROPCNT_EN
    logic [15:0] dcnt;
    // Saturating drop counter; an increment beats a same-cycle clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) dcnt <= '0;
      else if (drop_v[c]) begin
        if (dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
      end else if (ovf_clr[c]) dcnt <= '0;
    end
    assign dcnt_v[c] = dcnt;
`else
    assign dcnt_v[c] = '0;
`endif
  end

  // Register read mux
  always_comb begin
    wb_dat_o = '0;
    case (adr)
      8'h00: wb_dat_o[15:8] = 8'(en);
      8'h04: wb_dat_o[23:0] = {8'(cmd_tvalid), 8'(full_v), 8'(empty_v)};
      8'h08: wb_dat_o[7:0] = 8'(ovf);
      8'h0C: wb_dat_o = {8'(NCH), 8'(DATA_BITS), 8'(DEPTH_LOG2), 8'h01};
      default: begin
        for (int c = 0; c < NCH; c++) begin
          if (data_hit && (int'(idx) == c))
            wb_dat_o = {dcnt_v[c], 16'(cnt_v[c])};
        end
      end
    endcase
  end

endmodule

// File: tb/tb_surfturf_cmdqueue.sv
// tb_surfturf_cmdqueue: directed stimulus with scoreboard queues
// for Wishbone reads and per-channel stream output.
module tb_surfturf_cmdqueue;

  typedef struct packed {
    logic [1:0]  ch;
    logic [14:0] d;
  } sx_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        ack;
  logic        err;
  logic        rty;
  logic [31:0] rdat;
  logic [59:0] tdata;
  logic [3:0]  tvalid;
  logic [3:0]  tready = '0;
  logic        ovf_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rq[$];
  string       rn[$];
  sx_t         sq[$];

  always #5 clk = ~clk;

  surfturf_cmdqueue dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_we_i(we),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_sel_i(sel),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .wb_rty_o(rty),
    .wb_dat_o(rdat),
    .cmd_tdata(tdata),
    .cmd_tvalid(tvalid),
    .cmd_tready(tready),
    .overflow_o(ovf_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: read data and stream beats against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack && cyc && !we) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got %h want none", rdat);
        end else begin
          logic [31:0] e;
          string n;
          e = rq.pop_front();
          n = rn.pop_front();
          if (rdat !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, rdat, e);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (tvalid[c] && tready[c]) begin
          checks++;
          if (sq.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected ch %0d got %h want none",
                     c, tdata[c*15 +: 15]);
          end else begin
            sx_t e;
            e = sq.pop_front();
            if (e.ch != 2'(c) || tdata[c*15 +: 15] !== e.d) begin
              errors++;
              $display("FAIL beat ch %0d got %h want ch %0d %h",
                       c, tdata[c*15 +: 15], e.ch, e.d);
            end
          end
        end
      end
    end
  end

  task automatic wb_cycle(input logic w, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] rr);
    int n;
    cyc = 1'b1;
    stb = 1'b1;
    we = w;
    adr = a;
    dat = d;
    sel = s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
    tready = tready | rr;
    @(posedge clk);
    #1;
    tready = tready & ~rr;
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    wb_cycle(1'b1, a, d, 4'hF, 4'h0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e,
                    input string nm);
    rq.push_back(e);
    rn.push_back(nm);
    wb_cycle(1'b0, a, 32'h0, 4'hF, 4'h0);
  endtask

  task automatic push(input int c, input logic [14:0] d);
    sq.push_back(sx_t'({2'(c), d}));
    wr(10'(8'h40 + 4 * c), {17'h0, d});
  endtask

  task automatic wait_idle(input int c);
    int n;
    n = 0;
    while (tvalid[c] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_idle", 32'(tvalid[c]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want done");
    $fatal(1);
  end

  logic [31:0] d1exp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 32'(tvalid), 32'd0);
    chk("reset_tdata", tdata[31:0], 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: defaults and unmapped space
    rd(10'h0C, 32'h040F0401, "params");
    rd(10'h00, 32'h00000F00, "control");
    rd(10'h20, 32'h0, "unmapped");
    wr(10'h50, 32'h5);
    rd(10'h50, 32'h0, "data_ch4");
    chk("err_rty", {30'h0, err, rty}, 32'd0);
    chk("t1_tvalid", 32'(tvalid), 32'd0);

    // 2: single word fall-through
    push(0, 15'h1234);
    chk("t2_tvalid", 32'(tvalid[0]), 32'd1);
    chk("t2_tdata", 32'(tdata[14:0]), 32'h1234);
    rd(10'h40, 32'h1, "t2_count");
    tready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_popped", 32'(tvalid[0]), 32'd0);
    tready[0] = 1'b0;

    // 3: overflow on ch1
    for (int i = 0; i < 16; i++) push(1, 15'(i));
    wr(10'h44, 32'd16);
    rd(10'h04, 32'h0002020D, "t3_status");
    rd(10'h08, 32'h2, "t3_ovf");
    chk("t3_ovf_o", 32'(ovf_o), 32'd1);
`ifdef SURFTURF_CMDQUEUE_DROPCNT_EN
    d1exp = 32'h00010010;
`else
    d1exp = 32'h00000010;
`endif
    rd(10'h44, d1exp, "t3_data1");
    tready[1] = 1'b1;
    wait_idle(1);
    tready[1] = 1'b0;
    wr(10'h08, 32'h2);
    rd(10'h08, 32'h0, "t3_ovf_clr");
    chk("t3_ovf_o_clr", 32'(ovf_o), 32'd0);

    // 4: push and pop together on a full FIFO
    for (int i = 0; i < 16; i++) push(2, 15'(12'h200 + i));
    sq.push_back(sx_t'({2'd2, 15'h210}));
    wb_cycle(1'b1, 10'h48, 32'h210, 4'hF, 4'b0100);
    rd(10'h48, 32'h10, "t4_count");
    rd(10'h08, 32'h0, "t4_ovf");
    tready[2] = 1'b1;
    for (int i = 1; i < 4; i++) push(2, 15'(12'h210 + i));
    wait_idle(2);
    tready[2] = 1'b0;
    chk("t4_ovf_o", 32'(ovf_o), 32'd0);

    // 5: flush ch3
    for (int i = 0; i < 5; i++) wr(10'h4C, 32'h300 + i);
    rd(10'h4C, 32'h5, "t5_count");
    wr(10'h00, 32'h00000F08);
    chk("t5_tvalid", 32'(tvalid[3]), 32'd0);
    rd(10'h4C, 32'h0, "t5_flushed");
    rd(10'h08, 32'h0, "t5_ovf");
    wr(10'h4C, 32'h333);
    chk("t5_head", 32'(tdata[59:45]), 32'h333);
    wr(10'h00, 32'h00000F08);

    // 6: enable gating, then reset mid-drain
    wr(10'h00, 32'h00000E00);
    tready[0] = 1'b1;
    push(0, 15'h0AA);
    push(0, 15'h0BB);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_gated", 32'(tvalid[0]), 32'd0);
    rd(10'h00, 32'h00000E00, "t6_control");
    rd(10'h40, 32'h2, "t6_count");
    wr(10'h00, 32'h00000F00);
    wait_idle(0);
    tready[0] = 1'b0;
    for (int i = 0; i < 3; i++) wr(10'h40, 32'h70 + i);
    chk("t6_pending", 32'(tvalid[0]), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(tvalid), 32'd0);
    chk("t6_rst_tdata", tdata[31:0], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(10'h00, 32'h00000F00, "t6_rst_ctrl");
    rd(10'h40, 32'h0, "t6_rst_count");

    repeat (4) @(posedge clk);
    #1;
    chk("sq_empty", 32'(sq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
